// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: sweeps a {ecc[6:0], data[31:0]} array, rewrites
// single-bit-corrected words and logs/flags uncorrectable (double-bit) words.
module ecc_scrubber #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INTERVAL_W-1:0] interval,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [38:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [38:0]           mem_rdata,
  output logic                  dec_en,
  output logic [31:0]           dec_din,
  output logic [6:0]            dec_ecc_in,
  input  logic [31:0]           dec_dout,
  input  logic [6:0]            dec_ecc_out,
  input  logic                  dec_single,
  input  logic                  dec_double,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sec_count,
  output logic [15:0]           ded_count,
  output logic [ADDR_W-1:0]     ded_addr,
  output logic                  ded_irq,
  input  logic                  irq_clr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ECC_W  = 7;
  localparam int unsigned WORD_W = DATA_W + ECC_W;
  localparam int unsigned CNT_W  = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [INTERVAL_W-1:0] ival_q, ival_d;
  logic [INTERVAL_W-1:0] wait_q, wait_d;
  logic [WORD_W-1:0]     wdata_d;
  logic [CNT_W-1:0]      sec_d, ded_d;
  logic [ADDR_W-1:0]     ded_addr_d;
  logic                  irq_d;
  logic [DATA_W-1:0]     din_d;
  logic [ECC_W-1:0]      ecc_d;

  assign mem_addr = addr_q;

  // Next-state and next-register values; outputs are registered from state_d.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ival_d     = ival_q;
    wait_d     = wait_q;
    wdata_d    = mem_wdata;
    sec_d      = sec_count;
    ded_d      = ded_count;
    ded_addr_d = ded_addr;
    irq_d      = ded_irq & ~irq_clr;
    din_d      = '0;
    ecc_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ival_d = interval;
          sec_d  = '0;
          ded_d  = '0;
          addr_d = '0;
          if (interval != '0) begin
            wait_d  = interval;
            state_d = WAIT;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WAIT: begin
        wait_d = wait_q - INTERVAL_W'(1);
        if (wait_q <= INTERVAL_W'(1)) state_d = RD_REQ;
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) state_d = CHECK;
      end
      CHECK: begin
        if (dec_double) begin
          if (ded_count != '1) ded_d = ded_count + CNT_W'(1);
          // A coincident irq_clr re-arms capture, so this DED's address is taken.
          if (!ded_irq || irq_clr) ded_addr_d = addr_q;
          irq_d   = 1'b1;
          state_d = NEXT;
        end else if (dec_single) begin
          if (sec_count != '1) sec_d = sec_count + CNT_W'(1);
          wdata_d = {dec_ecc_out, dec_dout};
          state_d = WR_REQ;
        end else begin
          state_d = NEXT;
        end
      end
      WR_REQ: begin
        if (mem_gnt) state_d = NEXT;
      end
      NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (ival_q != '0) begin
            wait_d  = ival_q;
            state_d = WAIT;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture register feeding the decoder is only non-zero during CHECK.
    if (state_d == CHECK) begin
      din_d = mem_rdata[DATA_W-1:0];
      ecc_d = mem_rdata[WORD_W-1:DATA_W];
    end
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ival_q     <= '0;
      wait_q     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      dec_en     <= 1'b0;
      dec_din    <= '0;
      dec_ecc_in <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sec_count  <= '0;
      ded_count  <= '0;
      ded_addr   <= '0;
      ded_irq    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ival_q     <= ival_d;
      wait_q     <= wait_d;
      mem_req    <= (state_d == RD_REQ) || (state_d == WR_REQ);
      mem_we     <= (state_d == WR_REQ);
      mem_wdata  <= wdata_d;
      dec_en     <= (state_d == CHECK);
      dec_din    <= din_d;
      dec_ecc_in <= ecc_d;
      busy       <= (state_d != IDLE);
      done       <= (state_d == NEXT) && (addr_d == LAST_ADDR);
      sec_count  <= sec_d;
      ded_count  <= ded_d;
      ded_addr   <= ded_addr_d;
      ded_irq    <= irq_d;
    end
  end

endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber with a SECDED decoder model and a memory model.
module tb_ecc_scrubber;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] interval;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [38:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [38:0] mem_rdata;
  logic        dec_en;
  logic [31:0] dec_din;
  logic [6:0]  dec_ecc_in;
  logic [31:0] dec_dout;
  logic [6:0]  dec_ecc_out;
  logic        dec_single;
  logic        dec_double;
  logic        busy;
  logic        done;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic [1:0]  ded_addr;
  logic        ded_irq;
  logic        irq_clr;

  int vectors = 0;
  int miscompares = 0;

  ecc_scrubber #(.ADDR_W(2), .DEPTH(4), .INTERVAL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .interval(interval),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_en(dec_en), .dec_din(dec_din), .dec_ecc_in(dec_ecc_in),
    .dec_dout(dec_dout), .dec_ecc_out(dec_ecc_out),
    .dec_single(dec_single), .dec_double(dec_double),
    .busy(busy), .done(done), .sec_count(sec_count), .ded_count(ded_count),
    .ded_addr(ded_addr), .ded_irq(ded_irq), .irq_clr(irq_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hamming position of data bit j (positions 3..38 that are not powers of two).
  function automatic int pos_of(input int j);
    int n;
    n = 0;
    for (int q = 3; q < 39; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == j) return q;
        n++;
      end
    end
    return 0;
  endfunction

  function automatic logic [38:0] ecc_enc(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < 32; j++)
      if (d[j])
        for (int k = 0; k < 6; k++)
          if (((pos_of(j) >> k) & 1) == 1) c[k] = ~c[k];
    c[6] = ^{c[5:0], d};
    return {c, d};
  endfunction

  function automatic void ecc_dec(input logic [31:0] d, input logic [6:0] e,
                                  output logic [31:0] dout, output logic [6:0] eout,
                                  output logic sgl, output logic dbl);
    logic [38:0] re;
    logic [5:0]  s;
    logic        ov;
    re   = ecc_enc(d);
    s    = re[37:32] ^ e[5:0];
    ov   = ^{e, d};
    dout = d;
    eout = e;
    sgl  = 1'b0;
    dbl  = 1'b0;
    if (ov) begin
      sgl = 1'b1;
      if (s == 6'd0) eout[6] = ~e[6];
      else begin
        for (int k = 0; k < 6; k++) if (s == 6'(1 << k)) eout[k] = ~e[k];
        for (int j = 0; j < 32; j++) if (pos_of(j) == int'(s)) dout[j] = ~d[j];
      end
    end else if (s != 6'd0) begin
      dbl = 1'b1;
    end
  endfunction

  // Combinational decoder model, silent unless enabled.
  always_comb begin
    dec_dout    = '0;
    dec_ecc_out = '0;
    dec_single  = 1'b0;
    dec_double  = 1'b0;
    if (dec_en) ecc_dec(dec_din, dec_ecc_in, dec_dout, dec_ecc_out, dec_single, dec_double);
  end

  // Memory model: programmable grant stall and read latency; writes are logged.
  logic [38:0] img [0:3];
  int          gnt_stall = 0;
  int          rv_delay  = 1;
  int          gnt_wait  = 0;
  int          rcnt      = 0;
  logic        pend      = 1'b0;
  logic [38:0] rbuf      = '0;
  int          wr_cnt    = 0;
  logic [1:0]  last_wa   = '0;
  logic [38:0] last_wd   = '0;

  assign mem_gnt    = mem_req && (gnt_wait == 0);
  assign mem_rvalid = pend && (rcnt == 0);
  assign mem_rdata  = rbuf;

  always @(posedge clk) begin
    if (!mem_req) gnt_wait <= gnt_stall;
    else if (gnt_wait > 0) gnt_wait <= gnt_wait - 1;
  end

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      rcnt <= 0;
    end else if (mem_req && mem_gnt && !mem_we) begin
      pend <= 1'b1;
      rcnt <= rv_delay - 1;
      rbuf <= img[mem_addr];
    end else if (pend) begin
      if (rcnt == 0) pend <= 1'b0;
      else rcnt <= rcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_req && mem_gnt && mem_we) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
  end

  // Per-sweep observations filled in by run_sweep.
  int req_cyc[$];
  int first_addr;
  int unstable;
  int stalls;

  task automatic load_clean();
    img[0] = ecc_enc(32'h0000_0000);
    img[1] = ecc_enc(32'h1234_5678);
    img[2] = ecc_enc(32'hFFFF_FFFF);
    img[3] = ecc_enc(32'hA5A5_A5A5);
  endtask

  // Starts a sweep and follows it to done; cycle 1 is the cycle after start is accepted.
  task automatic run_sweep(input int iv, input int mid_start, input int clr_nth,
                           output int done_cyc);
    int          cyc;
    int          ded_seen;
    logic        prev_req;
    logic        prev_stall;
    logic [1:0]  pa;
    logic        pwe;
    logic [38:0] pwd;
    req_cyc.delete();
    first_addr = -1;
    unstable   = 0;
    stalls     = 0;
    ded_seen   = 0;
    done_cyc   = -1;
    prev_req   = 1'b0;
    prev_stall = 1'b0;
    pa         = '0;
    pwe        = 1'b0;
    pwd        = '0;
    @(negedge clk);
    start    = 1'b1;
    interval = 16'(iv);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 1000) begin
      if (mem_req && !prev_req && !mem_we) begin
        req_cyc.push_back(cyc);
        if (first_addr < 0) first_addr = int'(mem_addr);
      end
      if (prev_stall && (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pwe || mem_wdata !== pwd))
        unstable++;
      prev_req   = mem_req;
      prev_stall = mem_req && !mem_gnt;
      pa         = mem_addr;
      pwe        = mem_we;
      pwd        = mem_wdata;
      if (prev_stall) stalls++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      start = (cyc == mid_start);
      if (cyc == mid_start) interval = 16'd5;
      irq_clr = 1'b0;
      if (dec_en && dec_double) begin
        ded_seen++;
        if (ded_seen == clr_nth) irq_clr = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    irq_clr  = 1'b0;
    interval = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, mem_req, mem_we, dec_en, ded_irq} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, mem_req, mem_we, dec_en, ded_irq});
    end
    vectors++;
    if ({sec_count, ded_count} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got %h want 0", {sec_count, ded_count});
    end
    vectors++;
    if ({mem_addr, ded_addr, mem_wdata, dec_din, dec_ecc_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, ded_addr, mem_wdata, dec_din, dec_ecc_in});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int w0, d;
    load_clean();
    gnt_stall = 0;
    rv_delay  = 1;
    w0 = wr_cnt;
    run_sweep(0, 0, 0, d);
    vectors++;
    if (d !== 16) begin miscompares++; $display("FAIL clean_done_cycle: got %0d want 16", d); end
    vectors++;
    if (req_cyc.size() !== 4) begin miscompares++; $display("FAIL clean_reads: got %0d want 4", req_cyc.size()); end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL clean_writes: got %0d want 0", wr_cnt - w0); end
    vectors++;
    if ({sec_count, ded_count} !== 32'd0) begin
      miscompares++;
      $display("FAIL clean_counts: got %h want 0", {sec_count, ded_count});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL clean_idle_after: got %b want 00", {busy, done}); end
  endtask

  task automatic test_single();
    int w0, d;
    load_clean();
    img[2] = ecc_enc(32'hDEAD_BEEF) ^ (39'd1 << 5);
    w0 = wr_cnt;
    run_sweep(0, 0, 0, d);
    vectors++;
    if (d !== 17) begin miscompares++; $display("FAIL single_done_cycle: got %0d want 17", d); end
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL single_writes: got %0d want 1", wr_cnt - w0); end
    vectors++;
    if (last_wa !== 2'd2) begin miscompares++; $display("FAIL single_wr_addr: got %0d want 2", last_wa); end
    vectors++;
    if (last_wd !== ecc_enc(32'hDEAD_BEEF)) begin
      miscompares++;
      $display("FAIL single_wr_data: got %h want %h", last_wd, ecc_enc(32'hDEAD_BEEF));
    end
    vectors++;
    if (sec_count !== 16'd1) begin miscompares++; $display("FAIL single_sec_count: got %0d want 1", sec_count); end
    vectors++;
    if ({ded_irq, ded_count} !== 17'd0) begin
      miscompares++;
      $display("FAIL single_no_ded: got %h want 0", {ded_irq, ded_count});
    end
  endtask

  task automatic test_double();
    int w0, d;
    load_clean();
    img[1] = ecc_enc(32'h1234_5678) ^ (39'd1 << 3) ^ (39'd1 << 20);
    img[3] = ecc_enc(32'hA5A5_A5A5) ^ (39'd1 << 0) ^ (39'd1 << 38);
    w0 = wr_cnt;
    run_sweep(0, 0, 0, d);
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL double_writes: got %0d want 0", wr_cnt - w0); end
    vectors++;
    if (ded_count !== 16'd2) begin miscompares++; $display("FAIL double_ded_count: got %0d want 2", ded_count); end
    vectors++;
    if (sec_count !== 16'd0) begin miscompares++; $display("FAIL double_sec_cleared: got %0d want 0", sec_count); end
    vectors++;
    if (ded_addr !== 2'd1) begin miscompares++; $display("FAIL double_ded_addr: got %0d want 1", ded_addr); end
    vectors++;
    if (ded_irq !== 1'b1) begin miscompares++; $display("FAIL double_irq_set: got %b want 1", ded_irq); end
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    vectors++;
    if (ded_irq !== 1'b0) begin miscompares++; $display("FAIL double_irq_clr: got %b want 0", ded_irq); end
  endtask

  task automatic test_interval();
    int d;
    load_clean();
    gnt_stall = 2;
    rv_delay  = 3;
    @(negedge clk);
    run_sweep(3, 0, 0, d);
    vectors++;
    if (req_cyc.size() !== 4) begin
      miscompares++;
      $display("FAIL intv_reads: got %0d want 4", req_cyc.size());
    end else begin
      vectors++;
      if (req_cyc[0] !== 4) begin miscompares++; $display("FAIL intv_first_req: got %0d want 4", req_cyc[0]); end
      vectors++;
      if (req_cyc[1] - req_cyc[0] !== 11 || req_cyc[3] - req_cyc[2] !== 11) begin
        miscompares++;
        $display("FAIL intv_req_spacing: got %0d/%0d want 11/11", req_cyc[1] - req_cyc[0], req_cyc[3] - req_cyc[2]);
      end
    end
    vectors++;
    if (d !== 44) begin miscompares++; $display("FAIL intv_done_cycle: got %0d want 44", d); end
    vectors++;
    if (stalls !== 8) begin miscompares++; $display("FAIL intv_stall_cycles: got %0d want 8", stalls); end
    vectors++;
    if (unstable !== 0) begin miscompares++; $display("FAIL intv_req_stable: got %0d unstable want 0", unstable); end
    gnt_stall = 0;
    rv_delay  = 1;
  endtask

  task automatic test_reset_wr();
    int   w0, d, n;
    logic hit;
    load_clean();
    img[2] = ecc_enc(32'hDEAD_BEEF) ^ (39'd1 << 5);
    gnt_stall = 2;
    @(negedge clk);
    start = 1'b1;
    interval = '0;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (mem_req && mem_we) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (hit !== 1'b1) begin miscompares++; $display("FAIL rstwr_reach_wr: got %b want 1", hit); end
    vectors++;
    if (sec_count !== 16'd1) begin miscompares++; $display("FAIL rstwr_sec_before: got %0d want 1", sec_count); end
    w0 = wr_cnt;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_req, busy} !== 2'b00) begin miscompares++; $display("FAIL rstwr_abort: got %b want 00", {mem_req, busy}); end
    vectors++;
    if ({sec_count, ded_count} !== 32'd0) begin
      miscompares++;
      $display("FAIL rstwr_counts: got %h want 0", {sec_count, ded_count});
    end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL rstwr_no_write: got %0d want 0", wr_cnt - w0); end
    rst = 1'b0;
    gnt_stall = 0;
    w0 = wr_cnt;
    run_sweep(0, 0, 0, d);
    vectors++;
    if (first_addr !== 0) begin miscompares++; $display("FAIL rstwr_first_addr: got %0d want 0", first_addr); end
    vectors++;
    if (d !== 17) begin miscompares++; $display("FAIL rstwr_done_cycle: got %0d want 17", d); end
    vectors++;
    if (wr_cnt - w0 !== 1 || last_wa !== 2'd2) begin
      miscompares++;
      $display("FAIL rstwr_resweep_write: got %0d writes addr %0d want 1 addr 2", wr_cnt - w0, last_wa);
    end
  endtask

  task automatic test_midstart_clr();
    int w0, d;
    load_clean();
    img[1] = ecc_enc(32'h1234_5678) ^ (39'd1 << 3) ^ (39'd1 << 20);
    img[3] = ecc_enc(32'hA5A5_A5A5) ^ (39'd1 << 0) ^ (39'd1 << 38);
    w0 = wr_cnt;
    run_sweep(0, 6, 2, d);
    vectors++;
    if (d !== 16) begin miscompares++; $display("FAIL mid_done_cycle: got %0d want 16", d); end
    vectors++;
    if (ded_irq !== 1'b1) begin miscompares++; $display("FAIL mid_irq_set_wins: got %b want 1", ded_irq); end
    vectors++;
    if (ded_addr !== 2'd3) begin miscompares++; $display("FAIL mid_ded_addr_recapture: got %0d want 3", ded_addr); end
    vectors++;
    if (ded_count !== 16'd2) begin miscompares++; $display("FAIL mid_ded_count: got %0d want 2", ded_count); end
    vectors++;
    if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL mid_writes: got %0d want 0", wr_cnt - w0); end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    interval = '0;
    irq_clr  = 1'b0;
    load_clean();
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_interval();
    test_reset_wr();
    test_midstart_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
